// File: rtl/trap_pkg.sv
// ============================================================================
// Module  : trap_pkg
// Brief   : Shared state encoding and cause constants for the trap sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package trap_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        JUMP    = 3'd2,
        RETJUMP = 3'd3,
        FLUSH   = 3'd4
    } state_t;

    localparam logic [3:0] CAUSE_EXT_IRQ   = 4'd11;
    localparam logic [3:0] CAUSE_TIMER_IRQ = 4'd7;
    localparam int         INTERRUPT_BIT   = 31;

endpackage

`default_nettype wire

// File: rtl/trap_sequencer_if.sv
// ============================================================================
// Module  : trap_sequencer_if
// Brief   : Retirement, CSR and redirect signals between pipeline and sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface trap_sequencer_if;

    logic        external_interrupt_in;
    logic        timer_interrupt_in;
    logic        mstatus_mie_in;
    logic        meie_in;
    logic        mtie_in;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    logic        retire_valid_in;
    logic        stall_in;
    logic [31:0] retire_pc_in;
    logic [31:0] retire_next_pc_in;
    logic        exception_in;
    logic [3:0]  exception_cause_in;
    logic        mret_in;

    logic        suppress_commit_out;
    logic        trap_enter_out;
    logic [31:0] mepc_out;
    logic [31:0] mcause_out;
    logic        trap_return_out;
    logic        jump_valid_out;
    logic [31:0] jump_address_out;
    logic        flush_out;
    logic        busy_out;

    // Pipeline / CSR side
    modport master (
        output external_interrupt_in, timer_interrupt_in, mstatus_mie_in,
               meie_in, mtie_in, mtvec_in, mepc_in, retire_valid_in,
               stall_in, retire_pc_in, retire_next_pc_in, exception_in,
               exception_cause_in, mret_in,
        input  suppress_commit_out, trap_enter_out, mepc_out, mcause_out,
               trap_return_out, jump_valid_out, jump_address_out,
               flush_out, busy_out
    );

    // Sequencer side
    modport slave (
        input  external_interrupt_in, timer_interrupt_in, mstatus_mie_in,
               meie_in, mtie_in, mtvec_in, mepc_in, retire_valid_in,
               stall_in, retire_pc_in, retire_next_pc_in, exception_in,
               exception_cause_in, mret_in,
        output suppress_commit_out, trap_enter_out, mepc_out, mcause_out,
               trap_return_out, jump_valid_out, jump_address_out,
               flush_out, busy_out
    );

endinterface

`default_nettype wire

// File: rtl/trap_target_calc.sv
// ============================================================================
// Module  : trap_target_calc
// Brief   : Decodes mtvec and adds the vectored-interrupt offset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trap_target_calc (
    input  logic [31:0] mtvec,
    input  logic        interrupt,
    input  logic [3:0]  code,
    output logic [31:0] target
);

    logic [31:0] w_base;
    logic        w_vectored;

    assign w_base     = {mtvec[31:2], 2'b00};
    assign w_vectored = (mtvec[1:0] == 2'b01);

    // Offset wraps modulo 2^32 by construction of the 32-bit add.
    assign target = (w_vectored && interrupt) ? (w_base + {26'd0, code, 2'b00})
                                              : w_base;

endmodule

`default_nettype wire

// File: rtl/trap_sequencer.sv
// ============================================================================
// Module  : trap_sequencer
// Brief   : Machine-mode trap/interrupt entry and mret sequencing with flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trap_sequencer
    import trap_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    trap_sequencer_if.slave  bus
);

    localparam logic [3:0] c_flush_load = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_flush_cnt;
    logic        r_trap_enter;
    logic        r_trap_return;
    logic        r_jump_valid;
    logic        r_flush;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_jump_address;

    logic        w_accept;
    logic        w_ext_take;
    logic        w_tim_take;
    logic        w_is_exc;
    logic        w_is_ret;
    logic        w_is_irq;
    logic [3:0]  w_irq_code;
    logic [31:0] w_mcause;
    logic [31:0] w_trap_target;

    assign w_accept   = (r_state == IDLE) & bus.retire_valid_in & ~bus.stall_in;
    assign w_ext_take = bus.mstatus_mie_in & bus.meie_in & bus.external_interrupt_in;
    assign w_tim_take = bus.mstatus_mie_in & bus.mtie_in & bus.timer_interrupt_in;
    assign w_is_exc   = w_accept & bus.exception_in;
    assign w_is_ret   = w_accept & ~bus.exception_in & bus.mret_in;
    assign w_is_irq   = w_accept & ~bus.exception_in & ~bus.mret_in
                      & (w_ext_take | w_tim_take);
    assign w_irq_code = w_ext_take ? CAUSE_EXT_IRQ : CAUSE_TIMER_IRQ;

    always_comb begin
        w_mcause = 32'd0;
        if (w_is_irq) begin
            w_mcause[3:0]          = w_irq_code;
            w_mcause[INTERRUPT_BIT] = 1'b1;
        end else begin
            w_mcause[3:0] = bus.exception_cause_in;
        end
    end

    trap_target_calc u_target_calc (
        .mtvec     (bus.mtvec_in),
        .interrupt (w_is_irq),
        .code      (w_irq_code),
        .target    (w_trap_target)
    );

    // Gated by reset so the output is quiet while reset is held.
    assign bus.suppress_commit_out = rst & w_is_exc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_flush_cnt    <= 4'd0;
            r_trap_enter   <= 1'b0;
            r_trap_return  <= 1'b0;
            r_jump_valid   <= 1'b0;
            r_flush        <= 1'b0;
            r_mepc         <= 32'd0;
            r_mcause       <= 32'd0;
            r_jump_address <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_is_exc || w_is_irq) begin
                        r_state        <= SAVE;
                        r_trap_enter   <= 1'b1;
                        r_mepc         <= w_is_exc ? bus.retire_pc_in : bus.retire_next_pc_in;
                        r_mcause       <= w_mcause;
                        r_jump_address <= w_trap_target;
                    end else if (w_is_ret) begin
                        r_state        <= RETJUMP;
                        r_trap_return  <= 1'b1;
                        r_jump_valid   <= 1'b1;
                        r_flush        <= 1'b1;
                        r_jump_address <= bus.mepc_in;
                    end
                end
                SAVE: begin
                    r_state      <= JUMP;
                    r_trap_enter <= 1'b0;
                    r_jump_valid <= 1'b1;
                    r_flush      <= 1'b1;
                end
                JUMP, RETJUMP: begin
                    r_trap_return <= 1'b0;
                    r_jump_valid  <= 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        r_state     <= FLUSH;
                        r_flush_cnt <= c_flush_load;
                    end else begin
                        r_state <= IDLE;
                        r_flush <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt <= 4'd1) begin
                        r_state     <= IDLE;
                        r_flush     <= 1'b0;
                        r_flush_cnt <= 4'd0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_trap_enter  <= 1'b0;
                    r_trap_return <= 1'b0;
                    r_jump_valid  <= 1'b0;
                    r_flush       <= 1'b0;
                    r_flush_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.trap_enter_out   = r_trap_enter;
    assign bus.trap_return_out  = r_trap_return;
    assign bus.jump_valid_out   = r_jump_valid;
    assign bus.jump_address_out = r_jump_address;
    assign bus.flush_out        = r_flush;
    assign bus.mepc_out         = r_mepc;
    assign bus.mcause_out       = r_mcause;
    assign bus.busy_out         = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
// ============================================================================
// Module  : tb_trap_sequencer
// Brief   : Directed vector table, corner sequences and randomized model check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_trap_sequencer;

    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_sequencer_if bus();

    trap_sequencer #(.FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic        rv, stall, exc;
        logic [3:0]  cause;
        logic        mret, ext, tim, mie, meie, mtie;
        logic [31:0] mtvec, pc, npc, mepc_in;
        int          kind;   // 0 none, 1 trap entry, 2 mret
        logic        supp;
        logic [31:0] e_mepc, e_mcause, e_tgt;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(string name, logic rv, logic stall, logic exc,
                                logic [3:0] cause, logic mret, logic ext, logic tim,
                                logic mie, logic meie, logic mtie,
                                logic [31:0] mtvec, logic [31:0] pc, logic [31:0] npc,
                                logic [31:0] mepc_in, int kind, logic supp,
                                logic [31:0] e_mepc, logic [31:0] e_mcause,
                                logic [31:0] e_tgt);
        vec_t v;
        v.name = name; v.rv = rv; v.stall = stall; v.exc = exc; v.cause = cause;
        v.mret = mret; v.ext = ext; v.tim = tim; v.mie = mie; v.meie = meie;
        v.mtie = mtie; v.mtvec = mtvec; v.pc = pc; v.npc = npc; v.mepc_in = mepc_in;
        v.kind = kind; v.supp = supp; v.e_mepc = e_mepc; v.e_mcause = e_mcause;
        v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.retire_valid_in = 0; bus.stall_in = 0; bus.exception_in = 0;
        bus.exception_cause_in = 0; bus.mret_in = 0; bus.external_interrupt_in = 0;
        bus.timer_interrupt_in = 0; bus.mstatus_mie_in = 0; bus.meie_in = 0;
        bus.mtie_in = 0; bus.mtvec_in = 0; bus.retire_pc_in = 0;
        bus.retire_next_pc_in = 0; bus.mepc_in = 0;
    endtask

    task automatic drive(vec_t v);
        bus.retire_valid_in = v.rv; bus.stall_in = v.stall; bus.exception_in = v.exc;
        bus.exception_cause_in = v.cause; bus.mret_in = v.mret;
        bus.external_interrupt_in = v.ext; bus.timer_interrupt_in = v.tim;
        bus.mstatus_mie_in = v.mie; bus.meie_in = v.meie; bus.mtie_in = v.mtie;
        bus.mtvec_in = v.mtvec; bus.retire_pc_in = v.pc;
        bus.retire_next_pc_in = v.npc; bus.mepc_in = v.mepc_in;
    endtask

    // Follows the spec latency table for offsets k = 1 .. FC+2 after a boundary.
    task automatic check_seq(string name, int kind, logic [31:0] tgt,
                             logic [31:0] mepc, logic [31:0] mcause);
        for (int k = 1; k <= FC + 2; k++) begin
            logic e_enter, e_ret, e_jump, e_flush, e_busy;
            @(negedge clk);
            idle_inputs();
            #1;
            e_enter = (kind == 1) && (k == 1);
            e_ret   = (kind == 2) && (k == 1);
            e_jump  = ((kind == 1) && (k == 2)) || ((kind == 2) && (k == 1));
            e_flush = (kind == 1) ? (k >= 2 && k <= FC + 1) :
                      (kind == 2) ? (k >= 1 && k <= FC) : 1'b0;
            e_busy  = (kind == 1) ? (k <= FC + 1) : (kind == 2) ? (k <= FC) : 1'b0;
            chk({name, ".enter"}, 32'(bus.trap_enter_out), 32'(e_enter));
            chk({name, ".ret"},   32'(bus.trap_return_out), 32'(e_ret));
            chk({name, ".jump"},  32'(bus.jump_valid_out), 32'(e_jump));
            chk({name, ".flush"}, 32'(bus.flush_out), 32'(e_flush));
            chk({name, ".busy"},  32'(bus.busy_out), 32'(e_busy));
            if (e_enter) begin
                chk({name, ".mepc"},   bus.mepc_out, mepc);
                chk({name, ".mcause"}, bus.mcause_out, mcause);
            end
            if (e_jump) chk({name, ".target"}, bus.jump_address_out, tgt);
        end
    endtask

    // Randomized reference model state: one pending sequence at a time.
    int          m_cycle;
    int          m_t0;
    bit          m_act;
    bit          m_ret;
    logic [31:0] m_mepc, m_mcause, m_tgt;

    task automatic model_cycle();
        int   k;
        bit   idle, acc, ext_ok, tim_ok;
        logic e_enter, e_ret, e_jump, e_flush;
        logic [31:0] base;
        k      = m_cycle - m_t0;
        idle   = !m_act || (m_ret ? (k >= 1 + FC) : (k >= 2 + FC));
        e_enter = m_act && !m_ret && (k == 1);
        e_ret   = m_act &&  m_ret && (k == 1);
        e_jump  = m_act && (m_ret ? (k == 1) : (k == 2));
        e_flush = m_act && (m_ret ? (k >= 1 && k <= FC) : (k >= 2 && k <= 1 + FC));
        acc     = idle && bus.retire_valid_in && !bus.stall_in;
        chk("rnd.busy",  32'(bus.busy_out), 32'(!idle));
        chk("rnd.enter", 32'(bus.trap_enter_out), 32'(e_enter));
        chk("rnd.ret",   32'(bus.trap_return_out), 32'(e_ret));
        chk("rnd.jump",  32'(bus.jump_valid_out), 32'(e_jump));
        chk("rnd.flush", 32'(bus.flush_out), 32'(e_flush));
        chk("rnd.supp",  32'(bus.suppress_commit_out), 32'(acc && bus.exception_in));
        if (!idle) begin
            chk("rnd.target", bus.jump_address_out, m_tgt);
            if (!m_ret) begin
                chk("rnd.mepc",   bus.mepc_out, m_mepc);
                chk("rnd.mcause", bus.mcause_out, m_mcause);
            end
        end
        ext_ok = bus.external_interrupt_in && bus.mstatus_mie_in && bus.meie_in;
        tim_ok = bus.timer_interrupt_in && bus.mstatus_mie_in && bus.mtie_in;
        base   = bus.mtvec_in & 32'hFFFF_FFFC;
        if (acc) begin
            if (bus.exception_in) begin
                m_act = 1; m_ret = 0; m_t0 = m_cycle;
                m_mepc = bus.retire_pc_in;
                m_mcause = 32'(bus.exception_cause_in);
                m_tgt = base;
            end else if (bus.mret_in) begin
                m_act = 1; m_ret = 1; m_t0 = m_cycle;
                m_tgt = bus.mepc_in;
            end else if (ext_ok || tim_ok) begin
                int code;
                code = ext_ok ? 11 : 7;
                m_act = 1; m_ret = 0; m_t0 = m_cycle;
                m_mepc = bus.retire_next_pc_in;
                m_mcause = 32'h8000_0000 + 32'(code);
                m_tgt = (bus.mtvec_in[1:0] == 2'b01) ? base + 32'(4 * code) : base;
            end
        end
        m_cycle++;
    endtask

    initial begin
        vecs[0]  = mk("exc",        1,0,1,4'd2,0,0,0,0,0,0, 32'h200, 32'h100, 32'h104, 0, 1,1, 32'h100, 32'd2, 32'h200);
        vecs[1]  = mk("timer",      1,0,0,4'd0,0,0,1,1,0,1, 32'h201, 32'h40, 32'h44, 0, 1,0, 32'h44, 32'h8000_0007, 32'h21C);
        vecs[2]  = mk("exc_irq",    1,0,1,4'd5,0,1,1,1,1,1, 32'h201, 32'h300, 32'h304, 0, 1,1, 32'h300, 32'd5, 32'h200);
        vecs[3]  = mk("irq_mie0",   1,0,0,4'd0,0,1,1,0,1,1, 32'h201, 32'h200, 32'h204, 0, 0,0, 0, 0, 0);
        vecs[4]  = mk("ext_later",  1,0,0,4'd0,0,1,1,1,1,1, 32'h201, 32'h200, 32'h204, 0, 1,0, 32'h204, 32'h8000_000B, 32'h22C);
        vecs[5]  = mk("mret",       1,0,0,4'd0,1,0,0,0,0,0, 32'h200, 32'h50, 32'h54, 32'h80, 2,0, 0, 0, 32'h80);
        vecs[6]  = mk("tim_meie0",  1,0,0,4'd0,0,1,1,1,0,1, 32'h1001, 32'hC, 32'h10, 0, 1,0, 32'h10, 32'h8000_0007, 32'h101C);
        vecs[7]  = mk("stall",      1,1,1,4'd3,0,1,0,1,1,0, 32'h200, 32'h60, 32'h64, 0, 0,0, 0, 0, 0);
        vecs[8]  = mk("exc_mret",   1,0,1,4'd3,1,0,0,0,0,0, 32'h0, 32'h500, 32'h504, 32'h80, 1,1, 32'h500, 32'd3, 32'h0);
        vecs[9]  = mk("wrap",       1,0,0,4'd0,0,1,0,1,1,0, 32'hFFFF_FFFD, 32'h4, 32'h8, 0, 1,0, 32'h8, 32'h8000_000B, 32'h28);
        vecs[10] = mk("no_valid",   0,0,1,4'd4,0,0,0,0,0,0, 32'h200, 32'h70, 32'h74, 0, 0,0, 0, 0, 0);
        vecs[11] = mk("mtie0",      1,0,0,4'd0,0,0,1,1,0,0, 32'h200, 32'h80, 32'h84, 0, 0,0, 0, 0, 0);

        rst = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset.busy",   32'(bus.busy_out), 0);
        chk("reset.enter",  32'(bus.trap_enter_out), 0);
        chk("reset.jump",   32'(bus.jump_valid_out), 0);
        chk("reset.flush",  32'(bus.flush_out), 0);
        chk("reset.ret",    32'(bus.trap_return_out), 0);
        chk("reset.supp",   32'(bus.suppress_commit_out), 0);
        chk("reset.addr",   bus.jump_address_out, 0);
        chk("reset.mepc",   bus.mepc_out, 0);
        chk("reset.mcause", bus.mcause_out, 0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk({vecs[i].name, ".supp"}, 32'(bus.suppress_commit_out), 32'(vecs[i].supp));
            chk({vecs[i].name, ".idle"}, 32'(bus.busy_out), 0);
            check_seq(vecs[i].name, vecs[i].kind, vecs[i].e_tgt, vecs[i].e_mepc, vecs[i].e_mcause);
        end

        // Held exception: the next acceptance lands exactly on the IDLE-return cycle.
        @(negedge clk);
        idle_inputs();
        bus.retire_valid_in = 1; bus.exception_in = 1; bus.exception_cause_in = 4'd1;
        bus.retire_pc_in = 32'h600; bus.mtvec_in = 32'h400;
        for (int k = 0; k <= FC + 2; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("b2b.supp", 32'(bus.suppress_commit_out), 32'((k == 0) || (k == FC + 2)));
        end
        check_seq("b2b2", 1, 32'h400, 32'h600, 32'd1);

        // Interrupt presented only while the mret flush is in progress.
        @(negedge clk);
        idle_inputs();
        bus.retire_valid_in = 1; bus.mret_in = 1; bus.mepc_in = 32'h80;
        for (int k = 1; k <= FC + 2; k++) begin
            @(negedge clk);
            idle_inputs();
            if (k <= FC) begin
                bus.retire_valid_in = 1; bus.external_interrupt_in = 1;
                bus.mstatus_mie_in = 1; bus.meie_in = 1; bus.mtvec_in = 32'h201;
            end
            #1;
            chk("mretflush.enter", 32'(bus.trap_enter_out), 0);
            chk("mretflush.busy",  32'(bus.busy_out), 32'(k <= FC));
            if (k == 1) begin
                chk("mretflush.ret",  32'(bus.trap_return_out), 1);
                chk("mretflush.addr", bus.jump_address_out, 32'h80);
            end
        end

        // Reset asserted while in FLUSH.
        @(negedge clk);
        idle_inputs();
        bus.retire_valid_in = 1; bus.exception_in = 1; bus.exception_cause_in = 4'd2;
        bus.retire_pc_in = 32'h100; bus.mtvec_in = 32'h200;
        repeat (3) begin
            @(negedge clk);
            idle_inputs();
        end
        #1;
        chk("rstflush.pre", 32'(bus.flush_out), 1);
        #1 rst = 1'b0;
        #1;
        chk("rstflush.flush", 32'(bus.flush_out), 0);
        chk("rstflush.busy",  32'(bus.busy_out), 0);
        chk("rstflush.jump",  32'(bus.jump_valid_out), 0);
        chk("rstflush.addr",  bus.jump_address_out, 0);
        chk("rstflush.mepc",  bus.mepc_out, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("rstpost.enter", 32'(bus.trap_enter_out), 0);
            chk("rstpost.jump",  32'(bus.jump_valid_out), 0);
            chk("rstpost.flush", 32'(bus.flush_out), 0);
            chk("rstpost.busy",  32'(bus.busy_out), 0);
        end

        // Randomized phase against the reference model.
        m_cycle = 0; m_t0 = 0; m_act = 0; m_ret = 0;
        m_mepc = 0; m_mcause = 0; m_tgt = 0;
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] tv;
            @(negedge clk);
            bus.retire_valid_in       = ($urandom % 4) != 0;
            bus.stall_in              = ($urandom % 4) == 0;
            bus.exception_in          = ($urandom % 8) == 0;
            bus.exception_cause_in    = 4'($urandom);
            bus.mret_in               = ($urandom % 8) == 0;
            bus.external_interrupt_in = ($urandom % 3) == 0;
            bus.timer_interrupt_in    = ($urandom % 3) == 0;
            bus.mstatus_mie_in        = 1'($urandom);
            bus.meie_in               = 1'($urandom);
            bus.mtie_in               = 1'($urandom);
            tv = $urandom;
            tv[1:0] = ($urandom % 2) ? 2'b01 : 2'b00;
            bus.mtvec_in              = tv;
            bus.retire_pc_in          = $urandom;
            bus.retire_next_pc_in     = bus.retire_pc_in + 32'd4;
            bus.mepc_in               = $urandom;
            #1;
            model_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
